// File: rtl/axis_measure_ctrl_master_pkg.sv
// Shared constants, opcodes and FSM state type for the AXI4-Lite control master
// that drives the s_axi_control port of axis_measure_top.
package axis_measure_ctrl_master_pkg;

  localparam int unsigned STORE_DATA_WIDTH = 4;

  localparam logic [31:0] CONTROL_OFFSET    = 32'h0000_0000;
  localparam logic [31:0] CYCLES_OFFSET     = 32'h0000_0010;
  localparam logic [31:0] LAST_FRAME_OFFSET = 32'h0000_0018;
  localparam logic [31:0] SIG_CLEAR         = 32'h0000_0001;
  localparam logic [31:0] SIG_START         = 32'h0000_0002;

  localparam logic [1:0] CMD_WRITE    = 2'd0;
  localparam logic [1:0] CMD_READ     = 2'd1;
  localparam logic [1:0] CMD_SNAPSHOT = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } state_t;

  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_measure_ctrl_master.sv
// Single-outstanding AXI4-Lite initiator: turns host WRITE/READ/SNAPSHOT commands
// into bus transactions; every AXI and response output comes straight from a flop.
module axis_measure_ctrl_master
  import axis_measure_ctrl_master_pkg::*;
#(
  parameter logic [3:0] WSTRB_ALL = 4'hF
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [31:0]                   cmd_addr,
  input  logic [STORE_DATA_WIDTH*8-1:0] cmd_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [63:0]                   rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic [31:0]                   m_axi_control_awaddr,
  output logic                          m_axi_control_awvalid,
  input  logic                          m_axi_control_awready,
  output logic [31:0]                   m_axi_control_wdata,
  output logic [3:0]                    m_axi_control_wstrb,
  output logic                          m_axi_control_wvalid,
  input  logic                          m_axi_control_wready,
  input  logic [1:0]                    m_axi_control_bresp,
  input  logic                          m_axi_control_bvalid,
  output logic                          m_axi_control_bready,
  output logic [31:0]                   m_axi_control_araddr,
  output logic                          m_axi_control_arvalid,
  input  logic                          m_axi_control_arready,
  input  logic [31:0]                   m_axi_control_rdata,
  input  logic [1:0]                    m_axi_control_rresp,
  input  logic                          m_axi_control_rvalid,
  output logic                          m_axi_control_rready
);

  state_t      r_state,     w_state_nxt;
  logic        r_snap,      w_snap_nxt;
  logic        r_beat,      w_beat_nxt;
  logic        r_aw_done,   w_aw_done_nxt;
  logic        r_w_done,    w_w_done_nxt;
  logic        r_awvalid,   w_awvalid_nxt;
  logic        r_wvalid,    w_wvalid_nxt;
  logic        r_bready,    w_bready_nxt;
  logic        r_arvalid,   w_arvalid_nxt;
  logic        r_rready,    w_rready_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_cmd_ready, w_cmd_ready_nxt;
  logic [31:0] r_awaddr,    w_awaddr_nxt;
  logic [31:0] r_araddr,    w_araddr_nxt;
  logic [31:0] r_wdata,     w_wdata_nxt;
  logic [63:0] r_rsp_data,  w_rsp_data_nxt;
  logic [1:0]  r_rsp_resp,  w_rsp_resp_nxt;
  logic [3:0]  r_wstrb;

  logic w_aw_hs;
  logic w_w_hs;

  assign w_aw_hs = r_awvalid && m_axi_control_awready;
  assign w_w_hs  = r_wvalid  && m_axi_control_wready;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= ST_IDLE;
      r_snap      <= 1'b0;
      r_beat      <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_rsp_data  <= '0;
      r_rsp_resp  <= '0;
      r_wstrb     <= WSTRB_ALL;
    end else begin
      r_state     <= w_state_nxt;
      r_snap      <= w_snap_nxt;
      r_beat      <= w_beat_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_araddr    <= w_araddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_wstrb     <= WSTRB_ALL;
    end
  end

  // Next-state logic computes the registered value of every output, so each
  // valid/ready rises in the cycle after the decision that enables it.
  always_comb begin
    w_state_nxt     = r_state;
    w_snap_nxt      = r_snap;
    w_beat_nxt      = r_beat;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_awaddr_nxt    = r_awaddr;
    w_araddr_nxt    = r_araddr;
    w_wdata_nxt     = r_wdata;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_resp_nxt  = r_rsp_resp;

    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_rsp_resp_nxt = RESP_OKAY;
          w_rsp_data_nxt = '0;
          w_beat_nxt     = 1'b0;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_snap_nxt     = (cmd_op == CMD_SNAPSHOT);
          unique case (cmd_op)
            CMD_WRITE: begin
              w_awaddr_nxt  = cmd_addr;
              w_wdata_nxt   = cmd_wdata;
              w_awvalid_nxt = 1'b1;
              w_wvalid_nxt  = 1'b1;
              w_state_nxt   = ST_WR_REQ;
            end
            CMD_READ: begin
              w_araddr_nxt  = cmd_addr;
              w_arvalid_nxt = 1'b1;
              w_state_nxt   = ST_RD_REQ;
            end
            CMD_SNAPSHOT: begin
              w_araddr_nxt  = CYCLES_OFFSET;
              w_arvalid_nxt = 1'b1;
              w_state_nxt   = ST_RD_REQ;
            end
            default: begin
              w_rsp_resp_nxt  = RESP_SLVERR;
              w_rsp_valid_nxt = 1'b1;
              w_state_nxt     = ST_RSP;
            end
          endcase
        end
      end

      ST_WR_REQ: begin
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi_control_bvalid) begin
          w_rsp_resp_nxt  = resp_worst(r_rsp_resp, m_axi_control_bresp);
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RSP;
        end
      end

      ST_RD_REQ: begin
        if (m_axi_control_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        if (m_axi_control_rvalid) begin
          w_rsp_resp_nxt = resp_worst(r_rsp_resp, m_axi_control_rresp);
          w_rready_nxt   = 1'b0;
          if (r_beat) begin
            w_rsp_data_nxt[63:32] = m_axi_control_rdata;
            w_rsp_valid_nxt       = 1'b1;
            w_state_nxt           = ST_RSP;
          end else begin
            w_rsp_data_nxt[31:0] = m_axi_control_rdata;
            if (r_snap) begin
              // Lo is committed even on an error resp; only hi follows.
              w_beat_nxt    = 1'b1;
              w_araddr_nxt  = CYCLES_OFFSET + 32'd4;
              w_arvalid_nxt = 1'b1;
              w_state_nxt   = ST_RD_REQ;
            end else begin
              w_rsp_valid_nxt = 1'b1;
              w_state_nxt     = ST_RSP;
            end
          end
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  assign cmd_ready             = r_cmd_ready;
  assign rsp_valid             = r_rsp_valid;
  assign rsp_data              = r_rsp_data;
  assign rsp_resp              = r_rsp_resp;
  assign m_axi_control_awaddr  = r_awaddr;
  assign m_axi_control_awvalid = r_awvalid;
  assign m_axi_control_wdata   = r_wdata;
  assign m_axi_control_wstrb   = r_wstrb;
  assign m_axi_control_wvalid  = r_wvalid;
  assign m_axi_control_bready  = r_bready;
  assign m_axi_control_araddr  = r_araddr;
  assign m_axi_control_arvalid = r_arvalid;
  assign m_axi_control_rready  = r_rready;

endmodule

// File: tb/tb_axis_measure_ctrl_master.sv
// Bench for axis_measure_ctrl_master: behavioural AXI4-Lite responder with delay and
// resp knobs, plus a word-level reference model of what each command should return.
module tb_axis_measure_ctrl_master;
  import axis_measure_ctrl_master_pkg::*;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 ap_clk = ~ap_clk;

  axis_measure_ctrl_master #(.WSTRB_ALL(4'hF)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .m_axi_control_awaddr(awaddr), .m_axi_control_awvalid(awvalid), .m_axi_control_awready(awready),
    .m_axi_control_wdata(wdata), .m_axi_control_wstrb(wstrb), .m_axi_control_wvalid(wvalid),
    .m_axi_control_wready(wready),
    .m_axi_control_bresp(bresp), .m_axi_control_bvalid(bvalid), .m_axi_control_bready(bready),
    .m_axi_control_araddr(araddr), .m_axi_control_arvalid(arvalid), .m_axi_control_arready(arready),
    .m_axi_control_rdata(rdata), .m_axi_control_rresp(rresp), .m_axi_control_rvalid(rvalid),
    .m_axi_control_rready(rready)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- responder knobs (written only by the stimulus block)
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic [1:0]  bresp_k = '0, rresp_k0 = '0, rresp_k1 = '0;
  logic [31:0] init_mem [logic [31:0]];

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------- responder state (written only by the responder)
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  logic [31:0] aw_lat, w_lat, ar_lat;
  int aw_cnt, w_cnt, ar_cnt, rbeat;
  bit aw_f, w_f, ar_f, b_pend, r_pend;
  int aw_hi, w_hi, valid_seen, bready_viol, stab_viol, wstrb_bad;
  bit aw_pv, w_pv, ar_pv, rdy_pv;
  logic [31:0] aw_pa, w_pd, ar_pa;

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    if (init_mem.exists(a)) return init_mem[a];
    return default_word(a);
  endfunction

  always @(negedge ap_clk) begin
    bit aw_hs_prev, w_hs_prev, ar_hs_prev;
    if (ap_rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_f = 0; w_f = 0; ar_f = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_pv = 0; w_pv = 0; ar_pv = 0; rdy_pv = 0;
    end else begin
      if (rdy_pv && !cmd_ready) begin
        aw_log.delete(); w_log.delete(); ar_log.delete();
        rbeat = 0; aw_hi = 0; w_hi = 0; valid_seen = 0;
      end
      rdy_pv = cmd_ready;
      aw_hs_prev = awready; w_hs_prev = wready; ar_hs_prev = arready;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (awvalid || wvalid || arvalid) valid_seen++;
      if ((aw_pv && !awvalid && !aw_hs_prev) || (awvalid && aw_pv && !aw_hs_prev && awaddr !== aw_pa)) stab_viol++;
      if ((w_pv && !wvalid && !w_hs_prev) || (wvalid && w_pv && !w_hs_prev && wdata !== w_pd)) stab_viol++;
      if ((ar_pv && !arvalid && !ar_hs_prev) || (arvalid && ar_pv && !ar_hs_prev && araddr !== ar_pa)) stab_viol++;
      aw_pv = awvalid; aw_pa = awaddr; w_pv = wvalid; w_pd = wdata; ar_pv = arvalid; ar_pa = araddr;

      if (awready) begin
        aw_log.push_back(aw_lat); aw_f = 1; awready = 0; aw_cnt = 0;
      end else if (awvalid) begin
        if (aw_cnt >= aw_delay) begin awready = 1; aw_lat = awaddr; end
        else aw_cnt++;
      end
      if (wready) begin
        w_log.push_back(w_lat); w_f = 1; wready = 0; w_cnt = 0;
      end else if (wvalid) begin
        if (w_cnt >= w_delay) begin
          wready = 1; w_lat = wdata;
          if (wstrb !== 4'hF) wstrb_bad++;
        end else w_cnt++;
      end

      if (b_pend) begin bvalid = 0; b_pend = 0; aw_f = 0; w_f = 0; end
      if (aw_f && w_f && !bvalid) begin
        bvalid = 1; bresp = bresp_k;
        bus_mem[aw_log[$]] = w_log[$];
      end
      if (bready && !(aw_f && w_f)) bready_viol++;
      if (bvalid && bready) b_pend = 1;

      if (arready) begin
        ar_log.push_back(ar_lat); ar_f = 1; arready = 0; ar_cnt = 0;
      end else if (arvalid) begin
        if (ar_cnt >= ar_delay) begin arready = 1; ar_lat = araddr; end
        else ar_cnt++;
      end
      if (r_pend) begin rvalid = 0; r_pend = 0; end
      if (ar_f && !rvalid) begin
        rvalid = 1; rdata = bus_rd(ar_log[$]);
        rresp = (rbeat == 0) ? rresp_k0 : rresp_k1;
        rbeat++; ar_f = 0;
      end
      if (rvalid && rready) r_pend = 1;
    end
  end

  // ---------------- reference model: register-file view of the measurer
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_word(a);
  endfunction

  task automatic ref_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         output logic [63:0] ed, output logic [1:0] er, output int elat);
    case (op)
      2'd0: begin ref_mem[a] = d; ed = 64'd0; er = bresp_k; elat = 3; end
      2'd1: begin ed = {32'd0, ref_rd(a)}; er = rresp_k0; elat = 3; end
      2'd2: begin
        ed = {ref_rd(CYCLES_OFFSET + 32'd4), ref_rd(CYCLES_OFFSET)};
        er = (rresp_k0 > rresp_k1) ? rresp_k0 : rresp_k1;
        elat = 5;
      end
      default: begin ed = 64'd0; er = 2'b10; elat = 1; end
    endcase
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    init_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  // Issue one command, wait for the response, hold rsp_ready low for 'hold' cycles.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                        input int hold, output logic [63:0] gd, output logic [1:0] gr, output int lat);
    int n;
    bit bad;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge ap_clk); n++; end
    chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(posedge ap_clk);
    #1 cmd_valid = 0;
    n = 0; bad = 0;
    @(negedge ap_clk);
    while (!rsp_valid && n < 200) begin
      if (cmd_ready) bad = 1;
      @(negedge ap_clk); n++;
    end
    lat = n + 1;
    chk("rsp_timeout", 64'(rsp_valid), 64'd1);
    gd = rsp_data; gr = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      @(negedge ap_clk);
      if (!rsp_valid || rsp_data !== gd || rsp_resp !== gr || cmd_ready) bad = 1;
    end
    rsp_ready = 1;
    @(posedge ap_clk);
    #1 rsp_ready = 0;
    @(negedge ap_clk);
    chk("busy_and_hold", {63'd0, bad}, 64'd0);
  endtask

  logic [63:0] gd, ed;
  logic [1:0]  gr, er;
  int          lat, elat;

  initial begin
    logic [31:0] atab [7];
    logic [1:0]  op;
    logic [31:0] a, d;
    int          n;
    atab = '{32'h20, 32'h24, 32'h28, CONTROL_OFFSET, LAST_FRAME_OFFSET,
             CYCLES_OFFSET, CYCLES_OFFSET + 32'd4};

    repeat (3) @(negedge ap_clk);
    chk("reset_ctrl", {57'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 64'd0);
    chk("reset_wstrb", 64'(wstrb), 64'hF);
    chk("reset_addr", {awaddr, araddr}, 64'd0);
    chk("reset_wdata", 64'(wdata), 64'd0);
    chk("reset_rsp", rsp_data ^ 64'(rsp_resp), 64'd0);
    ap_rst = 0;
    repeat (2) @(negedge ap_clk);

    // WRITE CONTROL_OFFSET <= SIG_CLEAR, zero-wait
    ref_cmd(CMD_WRITE, CONTROL_OFFSET, SIG_CLEAR, ed, er, elat);
    do_cmd(CMD_WRITE, CONTROL_OFFSET, SIG_CLEAR, 0, gd, gr, lat);
    chk("wr_lat", 64'(lat), 64'd3);
    chk("wr_resp", 64'(gr), 64'd0);
    chk("wr_data", gd, 64'd0);
    chk("wr_beats", {32'(aw_log.size()), 32'(w_log.size())}, {32'd1, 32'd1});
    chk("wr_awaddr", 64'(aw_log[0]), 64'(CONTROL_OFFSET));
    chk("wr_wdata", 64'(w_log[0]), 64'(SIG_CLEAR));

    // READ LAST_FRAME_OFFSET: stream 0,0,10,5,20,30 with nonzero-only recording leaves 30
    preload(LAST_FRAME_OFFSET, 32'd30);
    ref_cmd(CMD_READ, LAST_FRAME_OFFSET, 32'd0, ed, er, elat);
    do_cmd(CMD_READ, LAST_FRAME_OFFSET, 32'd0, 1, gd, gr, lat);
    chk("rd_data", gd, 64'd30);
    chk("rd_resp", 64'(gr), 64'd0);
    chk("rd_lat", 64'(lat), 64'd3);

    // SNAPSHOT lo=0x123 hi=0x4
    preload(CYCLES_OFFSET, 32'h0000_0123);
    preload(CYCLES_OFFSET + 32'd4, 32'h0000_0004);
    do_cmd(CMD_SNAPSHOT, 32'hDEAD_BEEC, 32'd0, 2, gd, gr, lat);
    chk("snap_data", gd, 64'h0000_0004_0000_0123);
    chk("snap_lat", 64'(lat), 64'd5);
    chk("snap_nbeats", 64'(ar_log.size()), 64'd2);
    chk("snap_araddr", {ar_log[0], ar_log[1]}, {CYCLES_OFFSET, CYCLES_OFFSET + 32'd4});

    // Write with awready delayed 3 cycles
    aw_delay = 3;
    ref_cmd(CMD_WRITE, 32'h20, 32'hCAFE_0001, ed, er, elat);
    do_cmd(CMD_WRITE, 32'h20, 32'hCAFE_0001, 0, gd, gr, lat);
    chk("dly_w_hi", 64'(w_hi), 64'd1);
    chk("dly_aw_hi", 64'(aw_hi), 64'd4);
    chk("dly_bready_early", 64'(bready_viol), 64'd0);
    chk("dly_resp", 64'(gr), 64'(er));
    aw_delay = 0;

    // SNAPSHOT with SLVERR on the hi beat only
    rresp_k1 = 2'b10;
    ref_cmd(CMD_SNAPSHOT, 32'd0, 32'd0, ed, er, elat);
    do_cmd(CMD_SNAPSHOT, 32'd0, 32'd0, 0, gd, gr, lat);
    chk("snaperr_resp", 64'(gr), 64'd2);
    chk("snaperr_nbeats", 64'(ar_log.size()), 64'd2);
    chk("snaperr_data", gd, ed);
    rresp_k1 = 2'b00;

    // Illegal opcode
    do_cmd(2'd3, 32'h20, 32'd0, 1, gd, gr, lat);
    chk("ill_resp", 64'(gr), 64'd2);
    chk("ill_data", gd, 64'd0);
    chk("ill_no_valid", 64'(valid_seen), 64'd0);
    chk("ill_lat", 64'(lat), 64'd1);

    // Randomized commands against the reference model
    for (int it = 0; it < 30; it++) begin
      bit zw;
      op = 2'($urandom_range(0, 3));
      a  = atab[$urandom_range(0, 6)];
      d  = $urandom;
      aw_delay = (($urandom_range(0, 1)) != 0) ? $urandom_range(0, 3) : 0;
      w_delay  = (($urandom_range(0, 1)) != 0) ? $urandom_range(0, 3) : 0;
      ar_delay = (($urandom_range(0, 1)) != 0) ? $urandom_range(0, 3) : 0;
      bresp_k  = 2'($urandom_range(0, 3));
      rresp_k0 = 2'($urandom_range(0, 3));
      rresp_k1 = 2'($urandom_range(0, 3));
      zw = (aw_delay == 0) && (w_delay == 0) && (ar_delay == 0);
      ref_cmd(op, a, d, ed, er, elat);
      do_cmd(op, a, d, $urandom_range(0, 2), gd, gr, lat);
      chk($sformatf("rnd%0d_data", it), gd, ed);
      chk($sformatf("rnd%0d_resp", it), 64'(gr), 64'(er));
      if (zw) chk($sformatf("rnd%0d_lat", it), 64'(lat), 64'(elat));
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0;
    bresp_k = 0; rresp_k0 = 0; rresp_k1 = 0;
    chk("bready_before_done", 64'(bready_viol), 64'd0);
    chk("payload_stable", 64'(stab_viol), 64'd0);
    chk("wstrb_all", 64'(wstrb_bad), 64'd0);

    // Reset during a stalled READ
    ar_delay = 1000;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge ap_clk); n++; end
    cmd_valid = 1; cmd_op = CMD_READ; cmd_addr = 32'h24;
    @(posedge ap_clk);
    #1 cmd_valid = 0;
    repeat (3) @(negedge ap_clk);
    chk("stall_arvalid", 64'(arvalid), 64'd1);
    #2 ap_rst = 1;
    #1;
    chk("rst_async_valids", {60'd0, arvalid, rready, rsp_valid, awvalid}, 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    repeat (2) @(negedge ap_clk);
    chk("rst_hold_cmd_ready", 64'(cmd_ready), 64'd0);
    ar_delay = 0;
    ap_rst = 0;
    n = 0;
    while (!cmd_ready && n < 10) begin
      if (rsp_valid) n = 100;
      @(negedge ap_clk); n++;
    end
    chk("post_rst_ready_no_rsp", {63'd0, (n < 10)}, 64'd1);
    ref_cmd(CMD_READ, 32'h24, 32'd0, ed, er, elat);
    do_cmd(CMD_READ, 32'h24, 32'd0, 0, gd, gr, lat);
    chk("post_rst_read", gd, ed);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_measure_ctrl_master.md
# axis_measure_ctrl_master

AXI4-Lite initiator that drives the `s_axi_control` port of `axis_measure_top`. It turns single-beat host commands into AXI4-Lite transactions: register write, register read, or an atomic-sequence snapshot of the 64-bit cycle counter. It sits between an on-chip controller (sequencer, soft CPU bridge, or self-test engine) and the measurer, so the measurer can be cleared, started and polled without an external host.

## Interface
- `WSTRB_ALL`, default 4'hF: strobe driven on every write.
- `ap_clk` in 1: single clock; all logic rising-edge.
- `ap_rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` / `cmd_ready` in/out 1: command handshake.
- `cmd_op` in 2: command opcode.
  - 0 WRITE
  - 1 READ
  - 2 SNAPSHOT
  - 3 illegal
- `cmd_addr` in 32: byte address for WRITE/READ; ignored for SNAPSHOT.
- `cmd_wdata` in `STORE_DATA_WIDTH*8`: write data.
- `rsp_valid` / `rsp_ready` out/in 1: response handshake.
- `rsp_data` out 64: read data in [31:0] for READ; {hi,lo} for SNAPSHOT; 0 for WRITE.
- `rsp_resp` out 2: AXI response code (worst of all beats).
- `m_axi_control_awaddr` / `awvalid` / `awready`: write address channel, out 32 / out 1 / in 1.
- `m_axi_control_wdata` / `wstrb` / `wvalid` / `wready`: write data channel, out 32 / out 4 / out 1 / in 1.
- `m_axi_control_bresp` / `bvalid` / `bready`: write response channel, in 2 / in 1 / out 1.
- `m_axi_control_araddr` / `arvalid` / `arready`: read address channel, out 32 / out 1 / in 1.
- `m_axi_control_rdata` / `rresp` / `rvalid` / `rready`: read data channel, in 32 / in 2 / in 1 / out 1.

## Operation
- States:
  - IDLE
  - WR_REQ (AW and W presented together)
  - WR_RESP
  - RD_REQ
  - RD_DATA
  - RSP
- IDLE: `cmd_ready`=1. On handshake, latch op/addr/data and go to:
  - WRITE: WR_REQ
  - READ: RD_REQ with araddr=`cmd_addr`
  - SNAPSHOT: RD_REQ with araddr=`CYCLES_OFFSET`, beat=0
  - op 3: RSP directly with resp=2'b10 and no bus activity.
- WR_REQ: `awvalid` and `wvalid` are asserted together. Each drops independently after its own handshake (per-channel done flags). Once both are done, go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, record bresp and go to RSP.
- RD_REQ: `arvalid`=1 until arready, then go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, store rdata into lo (beat 0) or hi (beat 1).
  - SNAPSHOT beat 0: return to RD_REQ with araddr=`CYCLES_OFFSET`+4, beat=1.
  - Otherwise: go to RSP.
- RSP: `rsp_valid`=1, holding data/resp stable until `rsp_ready`, then go to IDLE.
- `rsp_resp` is the numerically largest resp seen in the command.
- SNAPSHOT always reads lo then hi. Lo is never re-read, even if resp≠OKAY.

## Timing
- Reset values:
  - All `*valid`, `bready`, `rready`, `rsp_valid` = 0.
  - `cmd_ready` = 0 while `ap_rst` is high.
  - `awaddr`/`araddr`/`wdata`/`rsp_data`/`rsp_resp` = 0.
  - `wstrb` = `WSTRB_ALL`.
  - State = IDLE.
- Reset mid-transaction: all valids/readies drop asynchronously. The responder is reset by the same `ap_rst`, and no completion is reported.
- All AXI outputs are registered. Payload is stable while its valid is high, and valid never drops before the handshake.
- Zero-wait responder, minimum latency from the cmd handshake cycle (C) to `rsp_valid`:
  - WRITE: `rsp_valid` high at C+3.
  - READ: `rsp_valid` high at C+3.
  - SNAPSHOT: `rsp_valid` high at C+5.
- AW and W may complete in either order or in the same cycle. A B beat is accepted only after both are done.
- `cmd_ready` is low from the accept cycle until the cycle after the rsp handshake. Throughput is one command outstanding.

## Structure
- Shared constants come from `axis_measure_defs.vh`: `STORE_DATA_WIDTH`, `CONTROL_OFFSET`, `CYCLES_OFFSET`, `LAST_FRAME_OFFSET`, `SIG_CLEAR`, `SIG_START`.
- Add to the same header: opcode constants `CMD_WRITE` / `CMD_READ` / `CMD_SNAPSHOT`, and the AXI resp codes.
- Single module, no sub-module. The FSM, channel done-flags and response registers are all local.

## Test plan
- WRITE `CONTROL_OFFSET`, data `SIG_CLEAR`, zero-wait `axis_measure_top`:
  - One AW and one W beat carrying exactly that addr/data, wstrb=4'hF.
  - rsp_resp=0 at C+3.
- READ `LAST_FRAME_OFFSET` after streaming 0,0,10,5,20,30 with RECORD_ONLY_NONZERO=1:
  - rsp_data[31:0] equals the measurer's last recorded nonzero frame.
  - rsp_resp=0.
- SNAPSHOT against a model returning 32'h0000_0123 (lo) and 32'h0000_0004 (hi):
  - rsp_data=64'h0000_0004_0000_0123.
  - araddr sequence is `CYCLES_OFFSET`, then `CYCLES_OFFSET`+4.
- Write with awready delayed 3 cycles, wready immediate:
  - wvalid drops after 1 cycle, awvalid after 4.
  - bready is asserted only after both are done.
- SNAPSHOT where the model returns rresp=2'b10 on beat 1 only: rsp_resp=2'b10 and both beats are issued.
- Illegal op 3: no AXI valid ever rises, rsp_resp=2'b10. Then assert `ap_rst` during a stalled READ: arvalid clears at once and cmd_ready=0 during reset.
